// File: rtl/pwm_compare_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_compare_if
// Description : Duty-value handshake bundle (valid/ready + data) between a
//               duty-cycle source (master) and pwm_compare (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_compare_if #(
    parameter int WIDTH = 4
);
    logic             duty_valid;
    logic [WIDTH:0]   duty_data;
    logic             duty_ready;

    modport master (
        output duty_valid,
        output duty_data,
        input  duty_ready
    );

    modport slave (
        input  duty_valid,
        input  duty_data,
        output duty_ready
    );
endinterface : pwm_compare_if
`default_nettype wire

// File: rtl/pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : pwm_compare
// Description : Compares an upstream free-running count against a
//               double-buffered duty value and drives a registered PWM
//               output plus a registered period-wrap pulse. New duty values
//               are taken over a valid/ready handshake into a one-deep
//               pending buffer and only become active on a wrap, so the
//               output never glitches mid-period.
//               Optional feature macro: PWM_COMP_OUT_EN - adds a
//               complementary output pwm_n with DEADTIME-cycle dead-time.
//               Without it pwm_n is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_compare #(
    parameter int WIDTH     = 4,
    parameter int DUTY_INIT = 8,
    parameter int DEADTIME  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] count,
    pwm_compare_if.slave          duty_if,
    output logic                  pwm_out,
    output logic                  pwm_n,
    output logic                  wrap_pulse,
    output logic [WIDTH:0]        duty_active
);

    localparam logic [WIDTH:0] c_DUTY_MAX  = (WIDTH+1)'(2**WIDTH);
    localparam logic [WIDTH:0] c_DUTY_INIT = (WIDTH+1)'(DUTY_INIT);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev_count;
    logic [WIDTH:0]   r_pending;
    logic [WIDTH:0]   r_duty_active;
    logic             r_pwm_out;
    logic             r_wrap_pulse;

    logic             w_wrap;
    logic             w_accept;
    logic             w_apply;
    logic [WIDTH:0]   w_duty_sat;
    logic [WIDTH:0]   w_duty_eff;
    logic             w_pwm_next;

    // A count that goes backwards marks a new period: either the natural
    // rollover or an upstream counter reset part-way through a period.
    assign w_wrap     = (count < r_prev_count);
    assign w_accept   = duty_if.duty_valid && (r_state == ST_EMPTY);
    assign w_apply    = (r_state == ST_FULL) && w_wrap;
    assign w_duty_sat = (duty_if.duty_data > c_DUTY_MAX) ? c_DUTY_MAX
                                                         : duty_if.duty_data;
    // The duty swapped in on a wrap must already govern that wrap's compare,
    // otherwise the first bit of the new period would use the old duty.
    assign w_duty_eff = w_apply ? r_pending : r_duty_active;
    assign w_pwm_next = ({1'b0, count} < w_duty_eff);

    // Pending-buffer FSM: EMPTY accepts one value, FULL waits for a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_pending     <= '0;
            r_duty_active <= c_DUTY_INIT;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_pending <= w_duty_sat;
                        r_state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_wrap) begin
                        r_duty_active <= r_pending;
                        r_state       <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Registered compare output, wrap pulse and previous-count history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_count <= '0;
            r_pwm_out    <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_prev_count <= count;
            r_pwm_out    <= w_pwm_next;
            r_wrap_pulse <= w_wrap;
        end
    end

    assign duty_if.duty_ready = (r_state == ST_EMPTY);
    assign pwm_out            = r_pwm_out;
    assign wrap_pulse         = r_wrap_pulse;
    assign duty_active        = r_duty_active;

`ifdef PWM_COMP_OUT_EN
    localparam int                c_DT_W    = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [c_DT_W-1:0] c_DT_LOAD = c_DT_W'(DEADTIME);
    localparam logic [c_DT_W-1:0] c_DT_ONE  = c_DT_W'(1);

    logic [c_DT_W-1:0] r_dt_cnt;
    logic              r_pwm_n;
    logic              w_edge;

    // Edges are seen on the next-value of pwm_out so pwm_n can drop in the
    // same cycle pwm_out rises; only pwm_n is delayed, pwm_out is untouched.
    assign w_edge = (w_pwm_next != r_pwm_out);

    // Complementary output: drop at once, rise only after DEADTIME quiet cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dt_cnt <= '0;
            r_pwm_n  <= 1'b0;
        end else if (w_edge) begin
            r_dt_cnt <= c_DT_LOAD;
            r_pwm_n  <= (DEADTIME == 0) ? ~w_pwm_next : 1'b0;
        end else if (r_dt_cnt != '0) begin
            r_dt_cnt <= r_dt_cnt - c_DT_ONE;
            r_pwm_n  <= (r_dt_cnt == c_DT_ONE) ? ~w_pwm_next : 1'b0;
        end else begin
            r_pwm_n  <= ~w_pwm_next;
        end
    end

    assign pwm_n = r_pwm_n;
`else
    // A negative dead-time has no meaning; nothing is built either way.
    if (DEADTIME < 0) begin : g_deadtime_unused
    end

    assign pwm_n = 1'b0;
`endif

endmodule : pwm_compare
`default_nettype wire
